pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch stage of the MIPS datapath.
- Consumes the next-PC value selected by the PC mux, holds the architectural fetch PC, and runs a req/ack handshake with instruction memory.
- Presents fetched instruction, PC+4 and a valid flag in an IF/ID register for decode.
- Supports stall and flush (redirect) from the hazard/branch logic.

---
 rtl/pc_fetch_unit_pkg.sv | 21 ++
 rtl/pc_fetch_unit_if_id_reg.sv | 90 +++++++++
 rtl/pc_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / instruction-fetch stage: FSM states,
// reset fetch address, bubble instruction and the PC increment helper.
package pc_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Sequential PC increment; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4, valid (and address-error flag
// when FETCH_ALIGN_CHECK_EN is defined). Flush beats stall; stall beats load;
// an unstalled cycle without a load becomes a bubble.
module pc_fetch_unit_if_id_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc4_i,
`ifdef FETCH_ALIGN_CHECK_EN
    input  logic            adel_i,
    output logic            adel_o,
`endif
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            adel_q, adel_d;
`endif

    // Next-state: flush clears, stall holds, load captures, otherwise bubble.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
        adel_d  = adel_q;
`endif
        if (flush_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
            adel_d  = 1'b0;
`endif
        end else if (!stall_i) begin
            if (load_i) begin
                valid_d = 1'b1;
                instr_d = instr_i;
                pc4_d   = pc4_i;
`ifdef FETCH_ALIGN_CHECK_EN
                adel_d  = adel_i;
`endif
            end else begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
                adel_d  = 1'b0;
`endif
            end
        end
    end

    // IF/ID state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            adel_q  <= 1'b0;
`endif
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
            adel_q  <= adel_d;
`endif
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign adel_o  = adel_q;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: holds the fetch PC, runs the
// req/ack handshake with instruction memory and feeds the IF/ID register.
// Optional: define FETCH_ALIGN_CHECK_EN to add the if_adel output; a
// misaligned PC then produces an address-error bubble instead of a request.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] next_pc,
    input  logic            stall,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc4,
    output logic            if_valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic            if_adel
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] buf_q, buf_d;

    logic            ld;
    logic [XLEN-1:0] ld_instr;
    logic [XLEN-1:0] ld_pc4;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            ld_adel;
`endif

    // Fetch FSM next-state, PC update, hold buffer and IF/ID load request.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        drop_d   = drop_q;
        buf_d    = buf_q;
        ld       = 1'b0;
        ld_instr = buf_q;
        ld_pc4   = pc_plus4(pc_q);
`ifdef FETCH_ALIGN_CHECK_EN
        ld_adel  = 1'b0;
`endif
        unique case (state_q)
            ST_REQ: begin
                if (flush) begin
                    // Redirect before issuing so the request uses the new PC.
                    pc_d = next_pc;
                end
`ifdef FETCH_ALIGN_CHECK_EN
                else if (pc_q[1:0] != 2'b00) begin
                    if (!stall) begin
                        ld       = 1'b1;
                        ld_instr = NOP_INSTR;
                        ld_adel  = 1'b1;
                        pc_d     = next_pc;
                    end
                end
`endif
                else begin
                    addr_d  = pc_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    state_d = ST_REQ;
                    drop_d  = 1'b0;
                    if (flush) begin
                        pc_d = next_pc;
                    end else if (!drop_q) begin
                        if (!stall) begin
                            ld       = 1'b1;
                            ld_instr = imem_rdata;
                            pc_d     = next_pc;
                        end else begin
                            buf_d   = imem_rdata;
                            state_d = ST_HOLD;
                        end
                    end
                end else if (flush) begin
                    // Bus transfer is never aborted; mark its data as stale.
                    pc_d   = next_pc;
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    ld       = 1'b1;
                    ld_instr = buf_q;
                    pc_d     = next_pc;
                    state_d  = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
        req_d = (state_d == ST_WAIT);
    end

    // Fetch state, PC, bus request and hold buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
            buf_q   <= buf_d;
        end
    end

    pc_fetch_unit_if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall_i (stall),
        .flush_i (flush),
        .load_i  (ld),
        .instr_i (ld_instr),
        .pc4_i   (ld_pc4),
`ifdef FETCH_ALIGN_CHECK_EN
        .adel_i  (ld_adel),
        .adel_o  (if_adel),
`endif
        .instr_o (if_instr),
        .pc4_o   (if_pc4),
        .valid_o (if_valid)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign pc_out    = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector tables, an asynchronous reset
// sequence and a randomized run against a transaction-level model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] NOP    = 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        adel_obs;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        if_adel;
    assign adel_obs = if_adel;
`else
    assign adel_obs = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_pc    (next_pc),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_out     (pc_out),
        .if_instr   (if_instr),
        .if_pc4     (if_pc4),
`ifdef FETCH_ALIGN_CHECK_EN
        .if_adel    (if_adel),
`endif
        .if_valid   (if_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] npc;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_adel;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_row(input logic s, input logic f, input logic a, input logic [31:0] rd,
                           input logic [31:0] np, input logic er, input logic [31:0] ea,
                           input logic [31:0] ep, input logic ev, input logic [31:0] ei,
                           input logic [31:0] e4, input logic ed);
        vec_t v;
        v.stall = s; v.flush = f; v.ack = a; v.rdata = rd; v.npc = np;
        v.e_req = er; v.e_addr = ea; v.e_pc = ep; v.e_valid = ev;
        v.e_instr = ei; v.e_pc4 = e4; v.e_adel = ed;
        tbl.push_back(v);
    endtask

    // Starts and ends on a negedge; each row is one clock.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            stall      = tbl[i].stall;
            flush      = tbl[i].flush;
            imem_ack   = tbl[i].ack;
            imem_rdata = tbl[i].rdata;
            next_pc    = tbl[i].npc;
            @(posedge clk);
            #1;
            chk($sformatf("%s%0d req", tag, i),   32'(imem_req),  32'(tbl[i].e_req));
            chk($sformatf("%s%0d addr", tag, i),  imem_addr,      tbl[i].e_addr);
            chk($sformatf("%s%0d pc", tag, i),    pc_out,         tbl[i].e_pc);
            chk($sformatf("%s%0d valid", tag, i), 32'(if_valid),  32'(tbl[i].e_valid));
            chk($sformatf("%s%0d instr", tag, i), if_instr,       tbl[i].e_instr);
            if (ALIGN) chk($sformatf("%s%0d adel", tag, i), 32'(adel_obs), 32'(tbl[i].e_adel));
            if (tbl[i].e_valid && !tbl[i].e_adel)
                chk($sformatf("%s%0d pc4", tag, i), if_pc4, tbl[i].e_pc4);
            @(negedge clk);
        end
        tbl.delete();
    endtask

    // Transaction-level reference: architectural PC, one outstanding bus
    // transfer (possibly marked stale), an optional parked instruction.
    logic [31:0] m_pc, m_addr, m_instr, m_pc4, m_buf;
    logic        m_valid, m_adel, m_inflight, m_drop, m_buffered;
    int          lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic m_bubble();
        if (!stall) begin
            m_valid = 1'b0; m_instr = NOP; m_adel = 1'b0;
        end
    endtask

    task automatic m_deliver(input logic [31:0] d);
        m_valid = 1'b1; m_instr = d; m_pc4 = m_pc + 32'd4; m_adel = 1'b0;
        m_pc = next_pc;
    endtask

    task automatic model_step();
        if (flush) begin
            m_valid = 1'b0; m_instr = NOP; m_adel = 1'b0; m_pc = next_pc;
            if (m_inflight && !imem_ack) begin
                m_drop = 1'b1;
            end else begin
                m_inflight = 1'b0; m_drop = 1'b0; m_buffered = 1'b0;
            end
        end else if (m_inflight) begin
            if (imem_ack) begin
                m_inflight = 1'b0;
                if (m_drop) begin
                    m_drop = 1'b0;
                    m_bubble();
                end else if (!stall) begin
                    m_deliver(imem_rdata);
                end else begin
                    m_buffered = 1'b1; m_buf = imem_rdata;
                end
            end else begin
                m_bubble();
            end
        end else if (m_buffered) begin
            if (!stall) begin
                m_deliver(m_buf);
                m_buffered = 1'b0;
            end
        end else if (ALIGN && (m_pc[1:0] != 2'b00)) begin
            if (!stall) begin
                m_valid = 1'b1; m_instr = NOP; m_adel = 1'b1;
                m_pc4 = m_pc + 32'd4; m_pc = next_pc;
            end
        end else begin
            m_inflight = 1'b1; m_addr = m_pc;
            lat = int'($urandom_range(0, 3));
            m_bubble();
        end
    endtask

    initial begin
        logic [31:0] tmp;
        int          r;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
        imem_rdata = '0; next_pc = '0;
        #12;
        chk("rst req",   32'(imem_req), 32'd0);
        chk("rst pc",    pc_out,        RST_PC);
        chk("rst addr",  imem_addr,     RST_PC);
        chk("rst valid", 32'(if_valid), 32'd0);
        chk("rst instr", if_instr,      NOP);
        chk("rst pc4",   if_pc4,        32'd0);
        if (ALIGN) chk("rst adel", 32'(adel_obs), 32'd0);

        // s f a rdata npc | req addr pc valid instr pc4 adel
        add_row(0,0,0, 32'h0,         32'h3004,      1, 32'h3000, 32'h3000, 0, NOP,           32'h0,    0);
        add_row(0,0,1, 32'hAAAA_0001, 32'h3004,      0, 32'h3000, 32'h3004, 1, 32'hAAAA_0001, 32'h3004, 0);
        add_row(0,0,0, 32'h0,         32'h3008,      1, 32'h3004, 32'h3004, 0, NOP,           32'h0,    0);
        add_row(0,0,1, 32'hAAAA_0002, 32'h3008,      0, 32'h3004, 32'h3008, 1, 32'hAAAA_0002, 32'h3008, 0);
        add_row(0,0,0, 32'h0,         32'h300C,      1, 32'h3008, 32'h3008, 0, NOP,           32'h0,    0);
        add_row(0,0,1, 32'hAAAA_0003, 32'h300C,      0, 32'h3008, 32'h300C, 1, 32'hAAAA_0003, 32'h300C, 0);
        add_row(0,0,0, 32'h0,         32'h3010,      1, 32'h300C, 32'h300C, 0, NOP,           32'h0,    0);
        add_row(0,0,0, 32'h0,         32'h3010,      1, 32'h300C, 32'h300C, 0, NOP,           32'h0,    0);
        add_row(0,0,0, 32'h0,         32'h3010,      1, 32'h300C, 32'h300C, 0, NOP,           32'h0,    0);
        add_row(0,0,1, 32'hBBBB_0004, 32'h3010,      0, 32'h300C, 32'h3010, 1, 32'hBBBB_0004, 32'h3010, 0);
        add_row(0,0,0, 32'h0,         32'h3014,      1, 32'h3010, 32'h3010, 0, NOP,           32'h0,    0);
        add_row(1,0,1, 32'hCCCC_0005, 32'h3014,      0, 32'h3010, 32'h3010, 0, NOP,           32'h0,    0);
        add_row(1,0,1, 32'h7777_7777, 32'h3014,      0, 32'h3010, 32'h3010, 0, NOP,           32'h0,    0);
        add_row(0,0,0, 32'h0,         32'h3014,      0, 32'h3010, 32'h3014, 1, 32'hCCCC_0005, 32'h3014, 0);
        add_row(0,0,0, 32'h0,         32'h3018,      1, 32'h3014, 32'h3014, 0, NOP,           32'h0,    0);
        add_row(0,1,0, 32'h0,         32'h4000,      1, 32'h3014, 32'h4000, 0, NOP,           32'h0,    0);
        add_row(0,0,1, 32'hDEAD_0006, 32'h9999_0000, 0, 32'h3014, 32'h4000, 0, NOP,           32'h0,    0);
        add_row(0,0,0, 32'h0,         32'h4004,      1, 32'h4000, 32'h4000, 0, NOP,           32'h0,    0);
        add_row(0,0,1, 32'hEEEE_0007, 32'hFFFF_FFFC, 0, 32'h4000, 32'hFFFF_FFFC, 1, 32'hEEEE_0007, 32'h4004, 0);
        add_row(0,0,0, 32'h0,         32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, NOP,     32'h0,    0);
        add_row(0,0,1, 32'h1111_0008, 32'h0,         0, 32'hFFFF_FFFC, 32'h0, 1, 32'h1111_0008,   32'h0,    0);
        add_row(0,0,0, 32'h0,         32'h4,         1, 32'h0,    32'h0,    0, NOP,           32'h0,    0);
        add_row(1,1,0, 32'h0,         32'h5000,      1, 32'h0,    32'h5000, 0, NOP,           32'h0,    0);
        add_row(0,0,1, 32'h2222_0009, 32'h6000,      0, 32'h0,    32'h5000, 0, NOP,           32'h0,    0);
        add_row(0,0,0, 32'h0,         32'h5004,      1, 32'h5000, 32'h5000, 0, NOP,           32'h0,    0);
        @(negedge clk);
        rst_n = 1'b1;
        run_table("basic");

        // Asynchronous reset while a fetch is outstanding.
        stall = 1'b0; flush = 1'b0; imem_ack = 1'b0; next_pc = 32'h5004;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst req",   32'(imem_req), 32'd0);
        chk("midrst pc",    pc_out,        RST_PC);
        chk("midrst addr",  imem_addr,     RST_PC);
        chk("midrst valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("restart req",  32'(imem_req), 32'd1);
        chk("restart addr", imem_addr,     RST_PC);
        chk("restart pc",   pc_out,        RST_PC);
        @(negedge clk);

`ifdef FETCH_ALIGN_CHECK_EN
        add_row(0,0,1, 32'h1234_5678, 32'h3002, 0, 32'h3000, 32'h3002, 1, 32'h1234_5678, 32'h3004, 0);
        add_row(0,0,0, 32'h0,         32'h3008, 0, 32'h3000, 32'h3008, 1, NOP,           32'h0,    1);
        add_row(1,0,0, 32'h0,         32'h300C, 1, 32'h3008, 32'h3008, 1, NOP,           32'h0,    1);
        add_row(0,0,0, 32'h0,         32'h300C, 1, 32'h3008, 32'h3008, 0, NOP,           32'h0,    0);
`else
        add_row(0,0,1, 32'h1234_5678, 32'h3002, 0, 32'h3000, 32'h3002, 1, 32'h1234_5678, 32'h3004, 0);
        add_row(0,0,0, 32'h0,         32'h3006, 1, 32'h3002, 32'h3002, 0, NOP,           32'h0,    0);
`endif
        run_table("align");

        // Randomized run against the reference model.
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
        m_pc = RST_PC; m_addr = RST_PC; m_instr = NOP; m_pc4 = '0; m_buf = '0;
        m_valid = 1'b0; m_adel = 1'b0; m_inflight = 1'b0; m_drop = 1'b0;
        m_buffered = 1'b0; lat = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            stall = ($urandom % 4) == 0;
            flush = ($urandom % 12) == 0;
            if (m_inflight) begin
                if (lat == 0) imem_ack = 1'b1;
                else begin imem_ack = 1'b0; lat--; end
            end else begin
                imem_ack = ($urandom % 6) == 0;
            end
            imem_rdata = (imem_ack && m_inflight) ? mem_word(m_addr) : $urandom;
            r = int'($urandom % 8);
            tmp = $urandom;
            if (r == 0)      next_pc = {tmp[31:2], 2'b00};
            else if (r == 1) next_pc = 32'hFFFF_FFFC;
            else             next_pc = m_pc + 32'd4;
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d req", c),   32'(imem_req), 32'(m_inflight));
            chk($sformatf("rnd%0d addr", c),  imem_addr,     m_addr);
            chk($sformatf("rnd%0d pc", c),    pc_out,        m_pc);
            chk($sformatf("rnd%0d valid", c), 32'(if_valid), 32'(m_valid));
            chk($sformatf("rnd%0d instr", c), if_instr,      m_instr);
            if (ALIGN) chk($sformatf("rnd%0d adel", c), 32'(adel_obs), 32'(m_adel));
            if (m_valid) chk($sformatf("rnd%0d pc4", c), if_pc4, m_pc4);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
